// File: rtl/payment_controller_pkg.sv
// Shared vending definitions: controller state encoding and coin denominations.
package payment_controller_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COLLECT  = 2'd1,
    S_DISPENSE = 2'd2,
    S_CHANGE   = 2'd3
  } state_t;

  localparam logic [4:0] COIN1_VAL = 5'd1;
  localparam logic [4:0] COIN2_VAL = 5'd2;
  localparam logic [4:0] COIN5_VAL = 5'd5;

  // Value of all coin pulses seen in one cycle (at most 8 units).
  function automatic logic [4:0] coin_sum(input logic c1, input logic c2, input logic c5);
    return (c1 ? COIN1_VAL : 5'd0) + (c2 ? COIN2_VAL : 5'd0) + (c5 ? COIN5_VAL : 5'd0);
  endfunction

endpackage

// File: rtl/payment_controller_timeout_timer.sv
// Inactivity counter: expired flags the enabled cycle in which the count sits at TIMEOUT_CYCLES-1.
module timeout_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         r_cnt <= '0;
    else if (clear)                  r_cnt <= '0;
    else if (enable && r_cnt != LAST) r_cnt <= r_cnt + 1'b1;
  end

  assign expired = enable && (r_cnt == LAST);

endmodule

// File: rtl/payment_controller.sv
// Vending payment FSM: latches a price, collects coins, dispenses and returns change or refunds.
module payment_controller
  import payment_controller_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_strobe,
  input  logic       id_valid,
  input  logic [3:0] val_product,
  input  logic       coin_1,
  input  logic       coin_2,
  input  logic       coin_5,
  input  logic       cancel,
  output logic [4:0] credit,
  output logic [3:0] price,
  output logic       busy,
  output logic       dispense,
  output logic       change_valid,
  output logic [4:0] change_amt,
  output logic       refund,
  output logic       invalid_id
);

  state_t     r_state;
  logic [4:0] r_credit;
  logic [3:0] r_price;
  logic [4:0] r_change_amt;
  logic       r_dispense, r_change_valid, r_refund, r_invalid_id;

  logic       w_coin, w_expired, w_abort;
  logic [4:0] w_sum, w_price5;

  assign w_coin   = coin_1 | coin_2 | coin_5;
  assign w_sum    = r_credit + coin_sum(coin_1, coin_2, coin_5);
  assign w_price5 = {1'b0, r_price};
  // A timeout only counts when no coin arrived that cycle.
  assign w_abort  = cancel | (w_expired & ~w_coin);

  timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   ((r_state != S_COLLECT) | w_coin),
    .enable  (r_state == S_COLLECT),
    .expired (w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_credit       <= '0;
      r_price        <= '0;
      r_change_amt   <= '0;
      r_dispense     <= 1'b0;
      r_change_valid <= 1'b0;
      r_refund       <= 1'b0;
      r_invalid_id   <= 1'b0;
    end else begin
      r_dispense     <= 1'b0;
      r_change_valid <= 1'b0;
      r_refund       <= 1'b0;
      r_invalid_id   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (id_strobe) begin
            if (id_valid && val_product != 4'd0) begin
              r_price  <= val_product;
              r_credit <= '0;
              r_state  <= S_COLLECT;
            end else begin
              r_invalid_id <= 1'b1;
            end
          end
        end
        S_COLLECT: begin
          if (w_abort) begin
            if (w_sum == 5'd0) begin
              r_credit <= '0;
              r_price  <= '0;
              r_state  <= S_IDLE;
            end else begin
              r_credit       <= w_sum;
              r_change_amt   <= w_sum;
              r_change_valid <= 1'b1;
              r_refund       <= 1'b1;
              r_state        <= S_CHANGE;
            end
          end else begin
            r_credit <= w_sum;
            if (w_sum >= w_price5) begin
              r_dispense <= 1'b1;
              r_state    <= S_DISPENSE;
            end
          end
        end
        S_DISPENSE: begin
          if (r_credit > w_price5) begin
            r_change_amt   <= r_credit - w_price5;
            r_change_valid <= 1'b1;
            r_state        <= S_CHANGE;
          end else begin
            r_credit <= '0;
            r_price  <= '0;
            r_state  <= S_IDLE;
          end
        end
        default: begin
          r_credit <= '0;
          r_price  <= '0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign credit       = r_credit;
  assign price        = r_price;
  assign busy         = (r_state != S_IDLE);
  assign dispense     = r_dispense;
  assign change_valid = r_change_valid;
  assign change_amt   = r_change_amt;
  assign refund       = r_refund;
  assign invalid_id   = r_invalid_id;

endmodule

// File: tb/tb_payment_controller.sv
// Directed bench for payment_controller with a queue-based scoreboard for output pulses.
module tb_payment_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_strobe = 1'b0, id_valid = 1'b0;
  logic [3:0] val_product = 4'd0;
  logic       coin_1 = 1'b0, coin_2 = 1'b0, coin_5 = 1'b0, cancel = 1'b0;
  logic [4:0] credit, change_amt;
  logic [3:0] price;
  logic       busy, dispense, change_valid, refund, invalid_id;

  payment_controller #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .id_strobe(id_strobe), .id_valid(id_valid),
    .val_product(val_product), .coin_1(coin_1), .coin_2(coin_2), .coin_5(coin_5),
    .cancel(cancel), .credit(credit), .price(price), .busy(busy),
    .dispense(dispense), .change_valid(change_valid), .change_amt(change_amt),
    .refund(refund), .invalid_id(invalid_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;   // 0 dispense, 1 change, 2 invalid_id
    logic [4:0] amt;
    logic       rfd;
  } ev_t;

  ev_t q[$];
  int  total = 0;
  int  bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [4:0] amt, input logic rfd);
    ev_t e;
    e.kind = kind; e.amt = amt; e.rfd = rfd;
    q.push_back(e);
  endtask

  task automatic pop_chk(input string name, input int kind);
    ev_t e;
    if (q.size() == 0) begin
      chk({name, "_unexpected"}, 1, 0);
    end else begin
      e = q.pop_front();
      chk({name, "_kind"}, kind, e.kind);
      if (kind == 1 && e.kind == 1) begin
        chk("change_amt", int'(change_amt), int'(e.amt));
        chk("refund", int'(refund), int'(e.rfd));
      end
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (dispense)     pop_chk("dispense", 0);
      if (change_valid) pop_chk("change", 1);
      if (invalid_id)   pop_chk("invalid_id", 2);
    end
  end

  // Each call presents one cycle of inputs starting #1 after a rising edge.
  task automatic drive(input logic s, input logic v, input logic [3:0] p,
                       input logic c1, input logic c2, input logic c5, input logic cn);
    id_strobe = s; id_valid = v; val_product = p;
    coin_1 = c1; coin_2 = c2; coin_5 = c5; cancel = cn;
    @(posedge clk); #1;
    id_strobe = 0; id_valid = 0; val_product = 0;
    coin_1 = 0; coin_2 = 0; coin_5 = 0; cancel = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic select(input logic [3:0] p);
    drive(1, 1, p, 0, 0, 0, 0);
  endtask

  initial begin
    #2;
    chk("rst_credit", int'(credit), 0);
    chk("rst_price", int'(price), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_change_amt", int'(change_amt), 0);
    @(posedge clk); #1;
    rst = 0;

    // Exact payment: 2+2+1 for price 5
    select(4'd5);
    chk("t1_price", int'(price), 5);
    chk("t1_busy", int'(busy), 1);
    drive(0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    expect_ev(0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("t1_credit", int'(credit), 5);
    idle(2);
    chk("t1_idle_busy", int'(busy), 0);
    chk("t1_idle_credit", int'(credit), 0);

    // Overpayment: 5+5 for price 8 -> change 2
    select(4'd8);
    drive(0, 0, 0, 0, 0, 1, 0);
    expect_ev(0, 0, 0);
    expect_ev(1, 5'd2, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    chk("t2_credit", int'(credit), 10);
    idle(3);

    // Rejected selections, then coin ignored in IDLE
    expect_ev(2, 0, 0);
    drive(1, 0, 4'd3, 0, 0, 0, 0);
    chk("t3_busy", int'(busy), 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    chk("t3_credit", int'(credit), 0);
    expect_ev(2, 0, 0);
    drive(1, 1, 4'd0, 0, 0, 0, 0);
    chk("t3b_busy", int'(busy), 0);
    idle(1);

    // Cancel with a coin in the same cycle: refund 2+1
    select(4'd6);
    drive(0, 0, 0, 0, 1, 0, 0);
    expect_ev(1, 5'd3, 1);
    drive(0, 0, 0, 1, 0, 0, 1);
    idle(3);
    chk("t4_change_hold", int'(change_amt), 3);
    chk("t4_busy", int'(busy), 0);

    // All three coins in one cycle, twice: 8 then 16 against price 15
    select(4'd15);
    drive(0, 0, 0, 1, 1, 1, 0);
    chk("t5_credit8", int'(credit), 8);
    expect_ev(0, 0, 0);
    expect_ev(1, 5'd1, 0);
    drive(0, 0, 0, 1, 1, 1, 0);
    chk("t5_credit16", int'(credit), 16);
    idle(3);

    // Timeout after a coin: refund arrives after 16 idle cycles
    select(4'd7);
    drive(0, 0, 0, 0, 1, 0, 0);
    idle(15);
    chk("t6_pre_timeout_busy", int'(busy), 1);
    chk("t6_pre_timeout_cv", int'(change_valid), 0);
    expect_ev(1, 5'd2, 1);
    idle(1);
    chk("t6_timeout_cv", int'(change_valid), 1);
    idle(2);

    // Cancel with zero credit: straight to IDLE, no change pulse
    select(4'd3);
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("t7_busy", int'(busy), 0);
    idle(2);

    // Reset mid-COLLECT discards credit without a refund
    select(4'd4);
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("t8_credit_before", int'(credit), 1);
    #2 rst = 1;
    #1;
    chk("t8_credit", int'(credit), 0);
    chk("t8_price", int'(price), 0);
    chk("t8_busy", int'(busy), 0);
    chk("t8_change_amt", int'(change_amt), 0);
    @(posedge clk); #1;
    rst = 0;

    // Selection accepted on the first edge after reset release
    select(4'd2);
    chk("t9_busy", int'(busy), 1);
    expect_ev(0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    idle(3);
    chk("t9_busy_end", int'(busy), 0);

    chk("sb_drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
